rtc_aou_wr_ctrl: RTL

Write sequencer between the RTC APB register decode and the always-on RTC register bank (match, control and divider registers). It buffers APB writes per target register, arbitrates them round-robin, and issues them as single-cycle write-enable pulses with a shared data bus. Each pulse is followed by a programmable settle gap. It also forwards the ETB start trigger so that the trigger never collides with a control-register write, which would otherwise lose the trigger.

---
 rtl/rtc_pkg.sv | 53 +++++
 rtl/rtc_rr_arb3.sv | 44 ++++
 rtl/rtc_aou_wr_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC always-on write sequencer:
//   - slot indices (one slot per target register in the AOU register bank)
//   - data widths for the narrow CR and DIV registers
//   - write-sequencer FSM state encoding
//   - small select-decoding helpers
// -----------------------------------------------------------------------------
package rtc_pkg;

  // Slot indices, same bit order as apb_wr_sel / wr_pending
  localparam logic [1:0] SLOT_MR  = 2'd0;
  localparam logic [1:0] SLOT_CR  = 2'd1;
  localparam logic [1:0] SLOT_DIV = 2'd2;

  // Implemented widths of the narrow registers
  localparam int unsigned CR_W  = 4;
  localparam int unsigned DIV_W = 20;

  // Write-sequencer FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } wr_state_e;

  // True when exactly one of the three select bits is set
  function automatic logic is_onehot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001:  r = 1'b1;
      3'b010:  r = 1'b1;
      3'b100:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // One-hot grant to slot index; falls back to the supplied index when the
  // vector is not one-hot so the round-robin pointer never moves spuriously
  function automatic logic [1:0] onehot_to_slot(input logic [2:0] v,
                                                input logic [1:0] fallback);
    logic [1:0] r;
    case (v)
      3'b001:  r = SLOT_MR;
      3'b010:  r = SLOT_CR;
      3'b100:  r = SLOT_DIV;
      default: r = fallback;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rtc_rr_arb3.sv
// -----------------------------------------------------------------------------
// rtc_rr_arb3
// Three-way round-robin arbiter, purely combinational. The search starts at
// the slot after last_gnt and wraps; the pointer register lives in the parent
// so it only advances when the parent actually takes the grant.
//   req      in  3  per-slot request
//   last_gnt in  2  index of the most recently granted slot
//   gnt      out 3  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rtc_rr_arb3
  import rtc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_gnt,
  output logic [2:0] gnt
);

  // Rotating priority search, one fixed order per pointer value
  always_comb begin
    gnt = 3'b000;
    case (last_gnt)
      SLOT_MR: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      SLOT_CR: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        // SLOT_DIV and the unused encoding both search MR first
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/rtc_aou_wr_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_aou_wr_ctrl
// Write sequencer between the RTC APB register decode and the always-on RTC
// register bank. APB writes are buffered per target register (MR, CR, DIV),
// arbitrated round-robin and issued as single-cycle write-enable pulses on a
// shared data bus, each followed by SETTLE_CYC idle cycles. The ETB start
// trigger is forwarded so it never lands in the same cycle as a CR write.
//
// Parameters
//   SETTLE_CYC  idle cycles after each pulse (0..15)
//   COALESCE    1: a write to a pending slot overwrites it
//               0: such a write stalls until the slot is granted
// Ports
//   pclk             in   1  clock
//   preset           in   1  synchronous active-high reset
//   apb_wr_vld       in   1  APB write request
//   apb_wr_sel       in   3  one-hot target [0] MR [1] CR [2] DIV
//   apb_wdata        in  32  write data
//   apb_wr_rdy       out  1  write accepted when vld && rdy
//   etb_trig_in      in   1  single-cycle ETB trigger
//   pdu_aou_wen_mr   out  1  MR write-enable pulse
//   pdu_aou_wen_cr   out  1  CR write-enable pulse
//   pdu_aou_wen_div  out  1  DIV write-enable pulse
//   pwdata           out 32  data accompanying the wen pulse
//   etb_rtc_trig     out  1  forwarded trigger
//   wr_pending       out  3  per-slot pending flags
//   busy             out  1  FSM active, slot pending or trigger pending
//   sel_err          out  1  pulse after an accepted write with bad select
// -----------------------------------------------------------------------------
module rtc_aou_wr_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter bit          COALESCE   = 1'b1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        apb_wr_vld,
  input  logic [2:0]  apb_wr_sel,
  input  logic [31:0] apb_wdata,
  output logic        apb_wr_rdy,
  input  logic        etb_trig_in,
  output logic        pdu_aou_wen_mr,
  output logic        pdu_aou_wen_cr,
  output logic        pdu_aou_wen_div,
  output logic [31:0] pwdata,
  output logic        etb_rtc_trig,
  output logic [2:0]  wr_pending,
  output logic        busy,
  output logic        sel_err
);

  // Counter preload so that SETTLE lasts exactly SETTLE_CYC cycles
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC) - 4'd1;

  // Registers
  wr_state_e   state_r;
  logic [3:0]  settle_cnt_r;
  logic [2:0]  pend_r;
  logic [31:0] data_mr_r;
  logic [CR_W-1:0]  data_cr_r;
  logic [DIV_W-1:0] data_div_r;
  logic [1:0]  last_gnt_r;
  logic [2:0]  wen_r;
  logic [31:0] pwdata_r;
  logic        trig_pend_r;
  logic        sel_err_r;

  // Combinational
  logic        accept_s;
  logic        sel_ok_s;
  logic [2:0]  set_s;
  logic        grant_s;
  logic [2:0]  arb_gnt_s;
  logic [2:0]  gnt_clr_s;
  logic [31:0] gnt_data_s;
  logic [1:0]  gnt_idx_s;
  logic        rdy_s;

  rtc_rr_arb3 u_arb (
    .req      (pend_r),
    .last_gnt (last_gnt_r),
    .gnt      (arb_gnt_s)
  );

  // Grant happens only from IDLE; gnt_clr_s is the set of slots drained this edge
  always_comb begin
    grant_s = (state_r == ST_IDLE) && (pend_r != 3'b000);
    if (grant_s) begin
      gnt_clr_s = arb_gnt_s;
    end else begin
      gnt_clr_s = 3'b000;
    end
  end

  // Data and slot index of the granted slot (narrow registers zero-extended)
  always_comb begin
    gnt_data_s = 32'd0;
    case (arb_gnt_s)
      3'b001:  gnt_data_s = data_mr_r;
      3'b010:  gnt_data_s = {{(32-CR_W){1'b0}}, data_cr_r};
      3'b100:  gnt_data_s = {{(32-DIV_W){1'b0}}, data_div_r};
      default: gnt_data_s = 32'd0;
    endcase
    gnt_idx_s = onehot_to_slot(arb_gnt_s, last_gnt_r);
  end

  // Ready: without coalescing, a write to a slot still holding undrained data
  // must wait; a slot being granted this very cycle frees up on the same edge
  always_comb begin
    if (COALESCE) begin
      rdy_s = 1'b1;
    end else begin
      rdy_s = ((apb_wr_sel & pend_r & ~gnt_clr_s) == 3'b000);
    end
  end

  // Accept decode: malformed selects are swallowed without touching any slot
  always_comb begin
    accept_s = apb_wr_vld && rdy_s;
    sel_ok_s = is_onehot3(apb_wr_sel);
    if (accept_s && sel_ok_s) begin
      set_s = apb_wr_sel;
    end else begin
      set_s = 3'b000;
    end
  end

  // Slot storage: a new accept on the grant edge wins over the clear, so the
  // old data goes out and the new data stays pending
  always_ff @(posedge pclk) begin
    if (preset) begin
      pend_r     <= 3'b000;
      data_mr_r  <= 32'd0;
      data_cr_r  <= '0;
      data_div_r <= '0;
      sel_err_r  <= 1'b0;
    end else begin
      pend_r    <= (pend_r & ~gnt_clr_s) | set_s;
      sel_err_r <= accept_s && !sel_ok_s;
      if (set_s[SLOT_MR])  data_mr_r  <= apb_wdata;
      if (set_s[SLOT_CR])  data_cr_r  <= apb_wdata[CR_W-1:0];
      if (set_s[SLOT_DIV]) data_div_r <= apb_wdata[DIV_W-1:0];
    end
  end

  // Issue FSM with registered wen/pwdata; the grant edge loads the pulse
  // registers so the pulse lines up with the ISSUE state
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      last_gnt_r   <= SLOT_DIV;
      wen_r        <= 3'b000;
      pwdata_r     <= 32'd0;
    end else begin
      wen_r    <= 3'b000;
      pwdata_r <= 32'd0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            wen_r      <= arb_gnt_s;
            pwdata_r   <= gnt_data_s;
            last_gnt_r <= gnt_idx_s;
            state_r    <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (SETTLE_CYC == 32'd0) begin
            state_r <= ST_IDLE;
          end else begin
            settle_cnt_r <= SETTLE_LAST;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == 4'd0) begin
            state_r <= ST_IDLE;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Trigger holding: a trigger blocked by a CR pulse stays pending one more
  // cycle so it lands after the CR write instead of being overwritten by it
  always_ff @(posedge pclk) begin
    if (preset) begin
      trig_pend_r <= 1'b0;
    end else begin
      trig_pend_r <= etb_trig_in || (trig_pend_r && wen_r[SLOT_CR]);
    end
  end

  assign apb_wr_rdy      = rdy_s;
  assign pdu_aou_wen_mr  = wen_r[SLOT_MR];
  assign pdu_aou_wen_cr  = wen_r[SLOT_CR];
  assign pdu_aou_wen_div = wen_r[SLOT_DIV];
  assign pwdata          = pwdata_r;
  assign etb_rtc_trig    = trig_pend_r && !wen_r[SLOT_CR];
  assign wr_pending      = pend_r;
  assign busy            = (state_r != ST_IDLE) || (pend_r != 3'b000) || trig_pend_r;
  assign sel_err         = sel_err_r;

endmodule
